alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Initiator side of the arithmetic unit interface. Accepts arithmetic commands over a valid/ready handshake and drives operands, function code and enable into the arithmetic unit. Waits for the unit's registered flag, captures the result and carry, then returns the result as two WIDTH_AB-bit beats, low half first, over a valid/ready response channel. Sits between the command front-end (register file / serial decoder) and the arithmetic unit.

Parameters:
WIDTH_AB, 16, operand width; the response beat width.
WIDTH_RES, 32, result width; must equal 2*WIDTH_AB.
TIMEOUT, 4, number of cycles to wait for arth_flag before an error response; legal range 1..15.

Ports:
clock  in  1  single clock, rising edge.
rest  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  sequencer can accept a command.
cmd_fun  in  4  function code; [1:0] selects 00 add, 01 sub, 10 mul, 11 div.
cmd_a  in  WIDTH_AB  signed operand A.
cmd_b  in  WIDTH_AB  signed operand B.
alu_a  out  WIDTH_AB  operand A to the arithmetic unit.
alu_b  out  WIDTH_AB  operand B to the arithmetic unit.
alu_fun  out  4  function code to the arithmetic unit.
alu_en  out  1  arth_enable to the arithmetic unit.
alu_res  in  WIDTH_RES  registered result from the arithmetic unit.
alu_flag  in  1  registered arth_flag from the arithmetic unit.
alu_carry  in  1  registered carry_out from the arithmetic unit.
rsp_valid  out  1  response beat valid.
rsp_ready  in  1  consumer accepts the beat.
rsp_data  out  WIDTH_AB  response beat data.
rsp_last  out  1  high on the high-half (second) beat.
rsp_carry  out  1  captured carry; held for both beats.
rsp_err  out  1  error response (divide by zero or timeout); held for both beats.

Behaviour:
- Reset (rest=1 at a rising edge) puts the FSM in IDLE and clears all outputs to 0: cmd_ready=0 during reset, 1 in the first IDLE cycle after it, alu_*=0, rsp_*=0, timeout counter=0, capture registers=0.
- Reset overrides everything, including mid-operation. An in-flight command is dropped with no response. A pending beat is discarded.
- FSM states: IDLE, ISSUE, WAIT, RSP_LO, RSP_HI.
- IDLE:
  - cmd_ready=1 and alu_en=0.
  - On cmd_valid && cmd_ready, latch cmd_a, cmd_b and cmd_fun into alu_a, alu_b and alu_fun.
  - If cmd_fun[1:0]==11 and cmd_b==0, do not issue. Load the response registers with data=0, carry=0, err=1 and go to RSP_LO.
  - Otherwise go to ISSUE.
- ISSUE: exactly one cycle with alu_en=1. Clear the timeout counter. Go to WAIT.
- WAIT:
  - alu_en=0. alu_a, alu_b and alu_fun stay stable until the response completes.
  - If alu_flag=1, capture alu_res and alu_carry and set err=0. For a unit with one-cycle registered latency this happens in the first WAIT cycle, so issue to capture is 2 cycles.
  - Else increment the counter. When the counter reaches TIMEOUT without alu_flag, capture data=0, carry=0, err=1.
  - Either outcome goes to RSP_LO.
- RSP_LO:
  - rsp_valid=1, rsp_data=captured[WIDTH_AB-1:0], rsp_last=0.
  - On rsp_ready go to RSP_HI. Otherwise hold all rsp_* outputs stable (no retraction).
- RSP_HI:
  - rsp_valid=1, rsp_data=captured[WIDTH_RES-1:WIDTH_AB], rsp_last=1.
  - On rsp_ready go to IDLE. cmd_ready rises in the following cycle; there is no same-cycle bypass.
- cmd_ready is 0 in every state except IDLE, so only one command is in flight.
- Throughput with rsp_ready held high: one command per 5 cycles (IDLE, ISSUE, WAIT, RSP_LO, RSP_HI).
- Results are passed through unmodified: no sign extension or truncation inside the sequencer. Carry is the unit's carry bit as delivered.
- alu_flag seen in any state other than WAIT is ignored.

Test Plan:
1. Add: cmd a=0x0003, b=0x0004, fun=0000 -> alu_en pulses exactly 1 cycle; beat0 data=0x0007 last=0; beat1 data=0x0000 last=1; err=0.
2. Signed multiply: a=0xFFFE (-2), b=0x0003, fun=0010 -> beats 0xFFFA then 0xFFFF; err=0.
3. Divide by zero: a=0x0010, b=0x0000, fun=0011 -> alu_en never asserted; beats 0x0000/0x0000 with err=1 on both.
4. Timeout: hold alu_flag=0, TIMEOUT=4 -> rsp_valid rises after 4 WAIT cycles with err=1 and data 0; cmd_ready returns to 1 only after both beats are accepted.
5. Backpressure: rsp_ready=0 for 3 cycles in RSP_LO and 2 cycles in RSP_HI -> rsp_data, rsp_last, rsp_carry and rsp_err stay stable; cmd_ready=0 throughout; a second cmd_valid is not accepted until IDLE.
6. Reset mid-WAIT: assert rest for 1 cycle -> all outputs 0 the next cycle; no response beat emitted; a new command is then accepted and completes normally (sub 5-7 -> 0xFFFE, 0xFFFF).

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// Command, arithmetic-unit and response channels of the ALU command sequencer.
// The master modport is the sequencer's view; the slave modport is the surrounding logic's view.
interface alu_cmd_sequencer_if #(
  parameter int unsigned WIDTH_AB  = 16,
  parameter int unsigned WIDTH_RES = 32
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [3:0]           cmd_fun;
  logic [WIDTH_AB-1:0]  cmd_a;
  logic [WIDTH_AB-1:0]  cmd_b;

  logic [WIDTH_AB-1:0]  alu_a;
  logic [WIDTH_AB-1:0]  alu_b;
  logic [3:0]           alu_fun;
  logic                 alu_en;
  logic [WIDTH_RES-1:0] alu_res;
  logic                 alu_flag;
  logic                 alu_carry;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WIDTH_AB-1:0]  rsp_data;
  logic                 rsp_last;
  logic                 rsp_carry;
  logic                 rsp_err;

  modport master (
    input  cmd_valid, cmd_fun, cmd_a, cmd_b,
    output cmd_ready,
    output alu_a, alu_b, alu_fun, alu_en,
    input  alu_res, alu_flag, alu_carry,
    output rsp_valid, rsp_data, rsp_last, rsp_carry, rsp_err,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_fun, cmd_a, cmd_b,
    input  cmd_ready,
    input  alu_a, alu_b, alu_fun, alu_en,
    output alu_res, alu_flag, alu_carry,
    input  rsp_valid, rsp_data, rsp_last, rsp_carry, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the arithmetic unit: issues one command, waits for the unit's flag
// (or a timeout), then returns the result as two beats, low half first.
module alu_cmd_sequencer #(
  parameter int unsigned WIDTH_AB  = 16,
  parameter int unsigned WIDTH_RES = 32,
  parameter int unsigned TIMEOUT   = 4
) (
  input  logic                clock,
  input  logic                rest,
  alu_cmd_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RSP_LO,
    S_RSP_HI
  } state_e;

  localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);

  state_e              state_q;
  logic                cmd_ready_q;
  logic [WIDTH_AB-1:0] alu_a_q;
  logic [WIDTH_AB-1:0] alu_b_q;
  logic [3:0]          alu_fun_q;
  logic                alu_en_q;
  logic [3:0]          cnt_q;
  logic [WIDTH_AB-1:0] cap_hi_q;
  logic                rsp_valid_q;
  logic [WIDTH_AB-1:0] rsp_data_q;
  logic                rsp_last_q;
  logic                rsp_carry_q;
  logic                rsp_err_q;

  logic                div_zero;

  assign div_zero = (bus.cmd_fun[1:0] == 2'b11) && (bus.cmd_b == '0);

  // Only the high half of the result needs holding: the low half goes straight
  // into the response data register when the result is captured.
  always_ff @(posedge clock) begin
    if (rest) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      alu_en_q    <= 1'b0;
      cnt_q       <= '0;
      cap_hi_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            alu_a_q     <= bus.cmd_a;
            alu_b_q     <= bus.cmd_b;
            alu_fun_q   <= bus.cmd_fun;
            if (div_zero) begin
              cap_hi_q    <= '0;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_last_q  <= 1'b0;
              rsp_carry_q <= 1'b0;
              rsp_err_q   <= 1'b1;
              state_q     <= S_RSP_LO;
            end else begin
              alu_en_q <= 1'b1;
              state_q  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          alu_en_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 4'd1;
          if (bus.alu_flag) begin
            cap_hi_q    <= bus.alu_res[WIDTH_RES-1:WIDTH_AB];
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= bus.alu_res[WIDTH_AB-1:0];
            rsp_last_q  <= 1'b0;
            rsp_carry_q <= bus.alu_carry;
            rsp_err_q   <= 1'b0;
            state_q     <= S_RSP_LO;
          end else if (cnt_q + 4'd1 == TIMEOUT_C) begin
            cap_hi_q    <= '0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b1;
            state_q     <= S_RSP_LO;
          end
        end
        S_RSP_LO: begin
          if (bus.rsp_ready) begin
            rsp_data_q <= cap_hi_q;
            rsp_last_q <= 1'b1;
            state_q    <= S_RSP_HI;
          end
        end
        S_RSP_HI: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_fun   = alu_fun_q;
  assign bus.alu_en    = alu_en_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a behavioural arithmetic unit with configurable
// flag latency, directed scenarios, then random commands against a reference model.
module tb_alu_cmd_sequencer;

  localparam int unsigned WAB  = 16;
  localparam int unsigned WRES = 32;
  localparam int unsigned TMO  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.WIDTH_AB(WAB), .WIDTH_RES(WRES)) bus_if ();

  alu_cmd_sequencer #(
    .WIDTH_AB (WAB),
    .WIDTH_RES(WRES),
    .TIMEOUT  (TMO)
  ) dut (
    .clock(clk),
    .rest (rst),
    .bus  (bus_if.master)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Arithmetic unit result: {carry, 32-bit result}; divide returns {rem, quot}.
  function automatic logic [32:0] unit_calc(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] f);
    logic signed [31:0] sa, sb, q, r;
    logic [16:0] s;
    logic [32:0] o;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    o  = '0;
    case (f[1:0])
      2'd0: begin
        s = {1'b0, a} + {1'b0, b};
        o = {s[16], sa + sb};
      end
      2'd1: o = {(a < b), sa - sb};
      2'd2: o = {1'b0, sa * sb};
      default: begin
        if (sb != 0) begin
          q = sa / sb;
          r = sa % sb;
          o = {1'b0, r[15:0], q[15:0]};
        end
      end
    endcase
    return o;
  endfunction

  // Behavioural unit: raises alu_flag for one cycle lat_cfg cycles after alu_en (0 = never).
  int unsigned lat_cfg = 1;
  int unsigned rem     = 0;
  int unsigned en_cnt  = 0;
  logic [15:0] hold_a, hold_b;
  logic [3:0]  hold_f;

  always @(posedge clk) begin
    if (rst) begin
      rem              <= 0;
      bus_if.alu_flag  <= 1'b0;
      bus_if.alu_res   <= '0;
      bus_if.alu_carry <= 1'b0;
    end else begin
      bus_if.alu_flag  <= 1'b0;
      bus_if.alu_res   <= $urandom;
      bus_if.alu_carry <= 1'($urandom);
      if (rem != 0) rem <= rem - 1;
      if (rem == 1) begin
        bus_if.alu_flag                    <= 1'b1;
        {bus_if.alu_carry, bus_if.alu_res} <= unit_calc(hold_a, hold_b, hold_f);
      end
      if (bus_if.alu_en) begin
        en_cnt <= en_cnt + 1;
        hold_a <= bus_if.alu_a;
        hold_b <= bus_if.alu_b;
        hold_f <= bus_if.alu_fun;
        if (lat_cfg == 1) begin
          bus_if.alu_flag                    <= 1'b1;
          {bus_if.alu_carry, bus_if.alu_res} <= unit_calc(bus_if.alu_a, bus_if.alu_b, bus_if.alu_fun);
          rem <= 0;
        end else if (lat_cfg == 0) begin
          rem <= 0;
        end else begin
          rem <= lat_cfg - 1;
        end
      end
    end
  end

  // Expected response: divide-by-zero errors immediately, a flag within TMO wait
  // cycles yields the unit result, otherwise a timeout error. k = cycles from accept to first beat.
  task automatic ref_rsp(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                         input int unsigned lat,
                         output logic [15:0] lo, output logic [15:0] hi,
                         output logic cy, output logic er,
                         output int unsigned k, output int unsigned ens);
    logic [32:0] u;
    if (f[1:0] == 2'b11 && b == 16'd0) begin
      lo = '0; hi = '0; cy = 1'b0; er = 1'b1; k = 1; ens = 0;
    end else if (lat >= 1 && lat <= TMO) begin
      u  = unit_calc(a, b, f);
      lo = u[15:0]; hi = u[31:16]; cy = u[32]; er = 1'b0; k = lat + 2; ens = 1;
    end else begin
      lo = '0; hi = '0; cy = 1'b0; er = 1'b1; k = TMO + 2; ens = 1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_cmd_ready"}, 32'(bus_if.cmd_ready), 32'd0);
    check_eq({tag, "_alu_a"},     32'(bus_if.alu_a),     32'd0);
    check_eq({tag, "_alu_b"},     32'(bus_if.alu_b),     32'd0);
    check_eq({tag, "_alu_fun"},   32'(bus_if.alu_fun),   32'd0);
    check_eq({tag, "_alu_en"},    32'(bus_if.alu_en),    32'd0);
    check_eq({tag, "_rsp_valid"}, 32'(bus_if.rsp_valid), 32'd0);
    check_eq({tag, "_rsp_data"},  32'(bus_if.rsp_data),  32'd0);
    check_eq({tag, "_rsp_last"},  32'(bus_if.rsp_last),  32'd0);
    check_eq({tag, "_rsp_carry"}, 32'(bus_if.rsp_carry), 32'd0);
    check_eq({tag, "_rsp_err"},   32'(bus_if.rsp_err),   32'd0);
  endtask

  task automatic wait_accept(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                             input int unsigned lat);
    int unsigned n;
    @(negedge clk);
    lat_cfg          = lat;
    bus_if.cmd_a     = a;
    bus_if.cmd_b     = b;
    bus_if.cmd_fun   = f;
    bus_if.cmd_valid = 1'b1;
    bus_if.rsp_ready = 1'b0;
    n = 0;
    while (bus_if.cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("cmd_ready_wait_expired", 32'(n >= 20), 32'd0);
    @(posedge clk);
    #1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_a     = 16'($urandom);
    bus_if.cmd_b     = 16'($urandom);
    bus_if.cmd_fun   = 4'($urandom);
  endtask

  task automatic check_beat(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] f, input logic [15:0] d, input logic last,
                            input logic cy, input logic er);
    check_eq({tag, "_valid"},     32'(bus_if.rsp_valid), 32'd1);
    check_eq({tag, "_data"},      32'(bus_if.rsp_data),  32'(d));
    check_eq({tag, "_last"},      32'(bus_if.rsp_last),  32'(last));
    check_eq({tag, "_carry"},     32'(bus_if.rsp_carry), 32'(cy));
    check_eq({tag, "_err"},       32'(bus_if.rsp_err),   32'(er));
    check_eq({tag, "_cmd_ready"}, 32'(bus_if.cmd_ready), 32'd0);
    check_eq({tag, "_alu_ops"},   {bus_if.alu_a[11:0], bus_if.alu_b[15:0], bus_if.alu_fun},
                                  {a[11:0], b, f});
  endtask

  task automatic run_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                         input int unsigned lat, input int unsigned stall_lo,
                         input int unsigned stall_hi,
                         input logic [15:0] exp_lo, input logic [15:0] exp_hi,
                         input logic exp_cy, input logic exp_er,
                         input int unsigned exp_k, input int unsigned exp_ens);
    int unsigned k, en0;
    en0 = en_cnt;
    wait_accept(a, b, f, lat);
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (bus_if.rsp_valid === 1'b1) break;
      check_eq("cmd_ready_busy", 32'(bus_if.cmd_ready), 32'd0);
    end
    check_eq("rsp_latency", k, exp_k);
    check_eq("alu_en_pulses", en_cnt - en0, exp_ens);
    for (int unsigned s = 0; s <= stall_lo; s++) begin
      if (s > 0) @(negedge clk);
      check_beat("beat_lo", a, b, f, exp_lo, 1'b0, exp_cy, exp_er);
      bus_if.rsp_ready = (s == stall_lo);
      bus_if.cmd_valid = (s != stall_lo);
      bus_if.cmd_a     = 16'($urandom);
      bus_if.cmd_b     = 16'($urandom);
    end
    for (int unsigned s = 0; s <= stall_hi; s++) begin
      @(negedge clk);
      check_beat("beat_hi", a, b, f, exp_hi, 1'b1, exp_cy, exp_er);
      bus_if.rsp_ready = (s == stall_hi);
      bus_if.cmd_valid = (s != stall_hi);
      bus_if.cmd_a     = 16'($urandom);
      bus_if.cmd_b     = 16'($urandom);
    end
    @(negedge clk);
    bus_if.rsp_ready = 1'b0;
    check_eq("post_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check_eq("post_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    check_eq("post_alu_en",    32'(bus_if.alu_en),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  initial begin
    logic [15:0] a, b, lo, hi;
    logic [3:0]  f;
    logic        cy, er;
    int unsigned lat, k, ens, r;

    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_a     = '0;
    bus_if.cmd_b     = '0;
    bus_if.cmd_fun   = '0;
    bus_if.rsp_ready = 1'b0;

    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_eq("first_idle_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);

    run_cmd(16'h0003, 16'h0004, 4'b0000, 1, 0, 0, 16'h0007, 16'h0000, 1'b0, 1'b0, 3, 1);
    run_cmd(16'hFFFE, 16'h0003, 4'b0010, 1, 0, 0, 16'hFFFA, 16'hFFFF, 1'b0, 1'b0, 3, 1);
    run_cmd(16'h0010, 16'h0000, 4'b0011, 1, 0, 0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1, 0);
    run_cmd(16'h1234, 16'h5678, 4'b0000, 0, 0, 0, 16'h0000, 16'h0000, 1'b0, 1'b1, 6, 1);
    run_cmd(16'hFFFF, 16'h0001, 4'b0000, 2, 3, 2, 16'h0000, 16'h0000, 1'b1, 1'b0, 4, 1);
    run_cmd(16'h0007, 16'hFFFE, 4'b0011, 4, 1, 1, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 6, 1);

    // Reset while the sequencer is waiting on the unit.
    wait_accept(16'h1111, 16'h2222, 4'b0000, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset_mid_wait");
    @(negedge clk);
    check_eq("reset_mid_wait_ready", 32'(bus_if.cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("reset_no_beat", 32'(bus_if.rsp_valid), 32'd0);
    end
    run_cmd(16'h0005, 16'h0007, 4'b0001, 1, 0, 0, 16'hFFFE, 16'hFFFF, 1'b1, 1'b0, 3, 1);

    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      f = 4'($urandom);
      if ($urandom_range(0, 4) == 0) b = '0;
      r   = $urandom_range(0, 9);
      lat = (r < 5) ? 1 : ((r == 9) ? 0 : r - 3);
      ref_rsp(a, b, f, lat, lo, hi, cy, er, k, ens);
      run_cmd(a, b, f, lat, $urandom_range(0, 3), $urandom_range(0, 3), lo, hi, cy, er, k, ens);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
